// File: rtl/id_scoreboard.sv
// Issue scoreboard for the decode stage: per-register result countdowns gate
// issue on RAW and out-of-order WAW hazards and count stalled cycles.
module id_scoreboard #(
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int LAT_W  = 3,
  parameter int SCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic              iss_rs1_en,
  input  logic [AW-1:0]     iss_rs1,
  input  logic              iss_rs2_en,
  input  logic [AW-1:0]     iss_rs2,
  input  logic              iss_we,
  input  logic [AW-1:0]     iss_rd,
  input  logic [LAT_W-1:0]  iss_lat,
  input  logic              flush,
  output logic [NREG-1:0]   busy,
  output logic [SCNT_W-1:0] stall_cnt
);

  logic [LAT_W-1:0] cnt_r     [NREG];
  logic [LAT_W-1:0] cnt_nxt_s [NREG];
  logic             raw1_s;
  logic             raw2_s;
  logic             waw_s;
  logic             fire_s;
  logic             rec_s;

  // Hazard detection and issue permission from the pre-update counts
  always_comb begin
    raw1_s    = iss_rs1_en && (iss_rs1 != AW'(0)) && (cnt_r[iss_rs1] != LAT_W'(0));
    raw2_s    = iss_rs2_en && (iss_rs2 != AW'(0)) && (cnt_r[iss_rs2] != LAT_W'(0));
    // A younger write may only retire after the older one is no longer visible
    waw_s     = iss_we && (iss_rd != AW'(0)) && (cnt_r[iss_rd] > iss_lat);
    iss_ready = !(raw1_s || raw2_s || waw_s) || !rst;
    fire_s    = iss_valid && iss_ready;
    rec_s     = fire_s && iss_we && (iss_rd != AW'(0)) && (iss_lat != LAT_W'(0));
  end

  // Next count per register: flush, then new issue, then countdown
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt_s[r] = {LAT_W{1'b0}};
      if ((r == 0) || flush) begin
        cnt_nxt_s[r] = {LAT_W{1'b0}};
      end else if (rec_s && (iss_rd == AW'(r))) begin
        cnt_nxt_s[r] = iss_lat;
      end else if (cnt_r[r] != LAT_W'(0)) begin
        cnt_nxt_s[r] = cnt_r[r] - LAT_W'(1);
      end else begin
        cnt_nxt_s[r] = {LAT_W{1'b0}};
      end
    end
  end

  // Count, busy and stall counter state
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_r[r] <= {LAT_W{1'b0}};
      end
      busy      <= {NREG{1'b0}};
      stall_cnt <= {SCNT_W{1'b0}};
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_r[r] <= cnt_nxt_s[r];
        busy[r]  <= (cnt_nxt_s[r] != LAT_W'(0));
      end
      if (iss_valid && !iss_ready && (stall_cnt != {SCNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + SCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: directed vector table, corner-case
// sequences and random stimulus against a release-time reference model.
module tb_id_scoreboard;
  localparam int NREG   = 32;
  localparam int AW     = 5;
  localparam int LAT_W  = 3;
  localparam int SCNT_W = 4;
  localparam int SMAX   = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              iss_valid, iss_ready, iss_rs1_en, iss_rs2_en, iss_we, flush;
  logic [AW-1:0]     iss_rs1, iss_rs2, iss_rd;
  logic [LAT_W-1:0]  iss_lat;
  logic [NREG-1:0]   busy;
  logic [SCNT_W-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  // Model: absolute cycle at which readers of each register become free.
  int free_at [NREG];
  int m_stall = 0;

  typedef struct {
    logic        v;
    logic        e1;
    logic [4:0]  rs1;
    logic        e2;
    logic [4:0]  rs2;
    logic        we;
    logic [4:0]  rd;
    logic [2:0]  lat;
    logic        fl;
    logic        rdy;
    logic [31:0] bsy;
    int          stl;
  } vec_t;

  vec_t tbl[$];

  id_scoreboard #(.NREG(NREG), .AW(AW), .LAT_W(LAT_W), .SCNT_W(SCNT_W)) dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1_en(iss_rs1_en), .iss_rs1(iss_rs1), .iss_rs2_en(iss_rs2_en),
    .iss_rs2(iss_rs2), .iss_we(iss_we), .iss_rd(iss_rd), .iss_lat(iss_lat),
    .flush(flush), .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic e1, input int rs1, input logic e2,
                              input int rs2, input logic we, input int rd, input int lat,
                              input logic fl, input logic rdy, input logic [31:0] bsy,
                              input int stl);
    vec_t t;
    t.v = v; t.e1 = e1; t.rs1 = 5'(rs1); t.e2 = e2; t.rs2 = 5'(rs2);
    t.we = we; t.rd = 5'(rd); t.lat = 3'(lat); t.fl = fl;
    t.rdy = rdy; t.bsy = bsy; t.stl = stl;
    return t;
  endfunction

  function automatic logic model_ready();
    logic blk;
    if (!rst) return 1'b1;
    blk = 1'b0;
    if (iss_rs1_en && iss_rs1 != 5'd0 && free_at[iss_rs1] > cyc) blk = 1'b1;
    if (iss_rs2_en && iss_rs2 != 5'd0 && free_at[iss_rs2] > cyc) blk = 1'b1;
    if (iss_we && iss_rd != 5'd0 && (free_at[iss_rd] - cyc) > int'(iss_lat)) blk = 1'b1;
    return !blk;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b = 32'd0;
    for (int r = 1; r < NREG; r++) b[r] = (free_at[r] > cyc);
    return b;
  endfunction

  task automatic do_cycle(input logic v, input logic e1, input int rs1, input logic e2,
                          input int rs2, input logic we, input int rd, input int lat,
                          input logic fl, output logic rdy_s, output logic [31:0] bsy_s,
                          output int stl_s);
    logic exp_rdy;
    @(negedge clk);
    iss_valid = v; iss_rs1_en = e1; iss_rs1 = AW'(rs1); iss_rs2_en = e2; iss_rs2 = AW'(rs2);
    iss_we = we; iss_rd = AW'(rd); iss_lat = LAT_W'(lat); flush = fl;
    #1;
    exp_rdy = model_ready();
    chk("ready", {31'd0, iss_ready}, {31'd0, exp_rdy});
    rdy_s = iss_ready;
    @(posedge clk);
    if (!rst) begin
      for (int r = 0; r < NREG; r++) free_at[r] = 0;
      m_stall = 0;
    end else begin
      if (v && !exp_rdy && m_stall < SMAX) m_stall++;
      if (fl) begin
        for (int r = 0; r < NREG; r++) free_at[r] = 0;
      end else if (v && exp_rdy && we && rd != 0 && lat != 0) begin
        free_at[rd] = cyc + lat + 1;
      end
    end
    cyc++;
    #1;
    chk("busy", busy, model_busy());
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    bsy_s = busy;
    stl_s = int'(stall_cnt);
  endtask

  initial begin
    logic        rdy;
    logic [31:0] bsy;
    int          stl;
    vec_t        t;

    for (int r = 0; r < NREG; r++) free_at[r] = 0;
    rst = 1'b0;
    iss_valid = 1'b0; iss_rs1_en = 1'b0; iss_rs2_en = 1'b0; iss_we = 1'b0; flush = 1'b0;
    iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0; iss_lat = '0;

    // Reset: ready held high, state cleared
    do_cycle(1, 1, 5, 0, 0, 1, 5, 3, 0, rdy, bsy, stl);
    do_cycle(1, 1, 5, 0, 0, 1, 5, 3, 0, rdy, bsy, stl);
    chk("reset_ready", {31'd0, rdy}, 32'd1);
    chk("reset_busy", bsy, 32'd0);
    chk("reset_stall", 32'(stl), 32'd0);
    rst = 1'b1;

    // load-use
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 1, 32'h20, 0));
    tbl.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1));
    tbl.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1));
    // lat=4 to x7, unrelated reader of x8, then waiting reader of x7
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 7, 4, 0, 1, 32'h80, 1));
    tbl.push_back(mk(1, 1, 8, 0, 0, 0, 0, 0, 0, 1, 32'h80, 1));
    tbl.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 32'h80, 2));
    tbl.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 32'h80, 3));
    tbl.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4));
    tbl.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 1, 32'h0, 4));
    // WAW: lat5 then lat1 to x3
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 5, 0, 1, 32'h8, 4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 32'h8, 5));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 32'h8, 6));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 32'h8, 7));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 32'h8, 8));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1, 0, 1, 32'h8, 8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 8));
    // flush drops both the pending x9 and a concurrent x10 issue
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 9, 6, 0, 1, 32'h200, 8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 8));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 10, 3, 1, 1, 32'h0, 8));
    tbl.push_back(mk(1, 1, 9, 1, 10, 0, 0, 0, 0, 1, 32'h0, 8));
    // x0 and lat=0 never tracked
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 7, 0, 1, 32'h0, 8));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 1, 32'h0, 8));
    tbl.push_back(mk(1, 1, 4, 1, 0, 0, 0, 0, 0, 1, 32'h0, 8));

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      do_cycle(t.v, t.e1, int'(t.rs1), t.e2, int'(t.rs2), t.we, int'(t.rd), int'(t.lat), t.fl,
               rdy, bsy, stl);
      chk($sformatf("tbl%0d_ready", i), {31'd0, rdy}, {31'd0, t.rdy});
      chk($sformatf("tbl%0d_busy", i), bsy, t.bsy);
      chk($sformatf("tbl%0d_stall", i), 32'(stl), 32'(t.stl));
    end

    // Saturation: 21 more stalled cycles from 8 must pin at 15
    for (int k = 0; k < 3; k++) begin
      do_cycle(1, 0, 0, 0, 0, 1, 12, 7, 0, rdy, bsy, stl);
      for (int j = 0; j < 7; j++) do_cycle(1, 1, 12, 0, 0, 0, 0, 0, 0, rdy, bsy, stl);
    end
    chk("sat_stall", 32'(stl), 32'd15);

    // Reset mid-operation with a concurrent fire
    do_cycle(1, 0, 0, 0, 0, 1, 12, 7, 0, rdy, bsy, stl);
    chk("pre_rst_busy", bsy, 32'h1000);
    rst = 1'b0;
    do_cycle(1, 1, 12, 0, 0, 1, 13, 5, 0, rdy, bsy, stl);
    chk("rst_ready", {31'd0, rdy}, 32'd1);
    chk("rst_busy", bsy, 32'd0);
    chk("rst_stall", 32'(stl), 32'd0);
    rst = 1'b1;
    do_cycle(1, 1, 12, 1, 13, 0, 0, 0, 0, rdy, bsy, stl);
    chk("post_rst_ready", {31'd0, rdy}, 32'd1);

    // Random traffic on a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0, rdy, bsy, stl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
